// File: rtl/demux_1_2_fila.sv
// Registered 1:2 demultiplexer: each accepted word is queued in the FIFO of the
// destination picked by controle, so either consumer may stall without blocking the other.

module demux_1_2_fila_fifo #(
    parameter int LARGURA      = 32,
    parameter int PROFUNDIDADE = 2
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              push_i,
    input  logic [LARGURA-1:0]                dado_i,
    input  logic                              pronta_i,
    output logic [LARGURA-1:0]                dado_o,
    output logic                              valida_o,
    output logic                              cheia_o,
    output logic [$clog2(PROFUNDIDADE):0]     ocupacao_o
);
    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CHEIA = CW'(PROFUNDIDADE);

    logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               push, pop;

    assign valida_o   = (count_q != '0);
    assign cheia_o    = (count_q == CHEIA);
    assign ocupacao_o = count_q;
    assign dado_o     = valida_o ? mem_q[rd_ptr_q] : '0;

    // Fullness is judged on the registered count only: a pop in the same cycle
    // does not free a slot for a push until the next cycle.
    assign push = push_i && !cheia_o;
    assign pop  = pronta_i && valida_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the count is cleared.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= dado_i;
    end
endmodule

module demux_1_2_fila #(
    parameter int LARGURA      = 32,
    parameter int PROFUNDIDADE = 2
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [LARGURA-1:0]                entrada,
    input  logic                              controle,
    input  logic                              entrada_valida,
    output logic                              entrada_pronta,
    output logic [LARGURA-1:0]                saidaA,
    output logic                              saidaA_valida,
    input  logic                              saidaA_pronta,
    output logic [LARGURA-1:0]                saidaB,
    output logic                              saidaB_valida,
    input  logic                              saidaB_pronta,
    output logic [$clog2(PROFUNDIDADE):0]     ocupacaoA,
    output logic [$clog2(PROFUNDIDADE):0]     ocupacaoB
);
    logic cheia_a, cheia_b;
    logic push_a, push_b;

    assign entrada_pronta = controle ? !cheia_b : !cheia_a;
    assign push_a = entrada_valida && !controle;
    assign push_b = entrada_valida &&  controle;

    demux_1_2_fila_fifo #(.LARGURA(LARGURA), .PROFUNDIDADE(PROFUNDIDADE)) u_fila_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (push_a),
        .dado_i     (entrada),
        .pronta_i   (saidaA_pronta),
        .dado_o     (saidaA),
        .valida_o   (saidaA_valida),
        .cheia_o    (cheia_a),
        .ocupacao_o (ocupacaoA)
    );

    demux_1_2_fila_fifo #(.LARGURA(LARGURA), .PROFUNDIDADE(PROFUNDIDADE)) u_fila_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (push_b),
        .dado_i     (entrada),
        .pronta_i   (saidaB_pronta),
        .dado_o     (saidaB),
        .valida_o   (saidaB_valida),
        .cheia_o    (cheia_b),
        .ocupacao_o (ocupacaoB)
    );
endmodule

// File: tb/tb_demux_1_2_fila.sv
// Scoreboard bench for demux_1_2_fila: stimulus queues expected words per destination,
// a negedge monitor compares the DUT heads, valids and occupancies against those queues.

module tb_demux_1_2_fila;
    localparam int W = 32;
    localparam int D = 2;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [W-1:0] entrada;
    logic         controle;
    logic         entrada_valida;
    logic         entrada_pronta;
    logic [W-1:0] saidaA, saidaB;
    logic         saidaA_valida, saidaB_valida;
    logic         saidaA_pronta, saidaB_pronta;
    logic [1:0]   ocupacaoA, ocupacaoB;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    always #5 clock = ~clock;

    demux_1_2_fila #(.LARGURA(W), .PROFUNDIDADE(D)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .entrada        (entrada),
        .controle       (controle),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .saidaA         (saidaA),
        .saidaA_valida  (saidaA_valida),
        .saidaA_pronta  (saidaA_pronta),
        .saidaB         (saidaB),
        .saidaB_valida  (saidaB_valida),
        .saidaB_pronta  (saidaB_pronta),
        .ocupacaoA      (ocupacaoA),
        .ocupacaoB      (ocupacaoB)
    );

    function automatic void check(string name, logic [W-1:0] got, logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endfunction

    // Monitor: queue state mirrors the DUT after each rising edge; pops are
    // applied to the model here, ahead of the edge on which the DUT pops.
    initial begin
        forever begin
            @(negedge clock);
            check("ocupacaoA", W'(ocupacaoA), W'(qa.size()));
            check("ocupacaoB", W'(ocupacaoB), W'(qb.size()));
            check("saidaA_valida", W'(saidaA_valida), W'(qa.size() != 0));
            check("saidaB_valida", W'(saidaB_valida), W'(qb.size() != 0));
            check("saidaA", saidaA, (qa.size() != 0) ? qa[0] : '0);
            check("saidaB", saidaB, (qb.size() != 0) ? qb[0] : '0);
            if (reset_n && saidaA_pronta && qa.size() != 0) void'(qa.pop_front());
            if (reset_n && saidaB_pronta && qb.size() != 0) void'(qb.pop_front());
        end
    end

    // Starts and ends one time unit after a rising edge.
    task automatic send(input logic ctl, input logic [W-1:0] data, input logic exp_rdy);
        controle       = ctl;
        entrada        = data;
        entrada_valida = 1'b1;
        @(negedge clock);
        check("entrada_pronta", W'(entrada_pronta), W'(exp_rdy));
        @(posedge clock);
        #1;
        if (exp_rdy) begin
            if (ctl) qb.push_back(data);
            else     qa.push_back(data);
        end
        entrada_valida = 1'b0;
        entrada        = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        entrada        = '0;
        controle       = 1'b0;
        entrada_valida = 1'b0;
        saidaA_pronta  = 1'b0;
        saidaB_pronta  = 1'b0;
        #1;
        check("rst entrada_pronta", W'(entrada_pronta), 1);
        check("rst ocupacaoA", W'(ocupacaoA), 0);
        idle(3);
        reset_n = 1'b1;
        idle(3);

        // single transfers
        send(1'b0, 8, 1'b1);
        idle(1);
        send(1'b1, 10, 1'b1);
        idle(1);
        saidaA_pronta = 1'b1;
        saidaB_pronta = 1'b1;
        idle(2);
        saidaA_pronta = 1'b0;
        saidaB_pronta = 1'b0;

        // fill A with consumer stalled
        send(1'b0, 30, 1'b1);
        send(1'b0, 40, 1'b1);
        controle = 1'b0;
        #1;
        check("full A pronta ctl0", W'(entrada_pronta), 0);
        controle = 1'b1;
        #1;
        check("full A pronta ctl1", W'(entrada_pronta), 1);
        send(1'b1, 50, 1'b1);

        // drain A in order
        saidaA_pronta = 1'b1;
        idle(3);
        saidaA_pronta = 1'b0;

        // full with simultaneous pop: no bypass
        send(1'b0, 60, 1'b1);
        send(1'b0, 70, 1'b1);
        saidaA_pronta = 1'b1;
        send(1'b0, 80, 1'b0);
        saidaA_pronta = 1'b0;
        check("full pop ocupacaoA", W'(ocupacaoA), 1);
        send(1'b0, 80, 1'b1);
        check("retry ocupacaoA", W'(ocupacaoA), 2);
        saidaA_pronta = 1'b1;
        saidaB_pronta = 1'b1;
        idle(4);
        saidaB_pronta = 1'b0;

        // steady stream with pointer wrap
        for (int i = 1; i <= 10; i++) send(1'b0, W'(i), 1'b1);
        idle(3);
        saidaA_pronta = 1'b0;

        // asynchronous reset mid-operation
        send(1'b0, 90, 1'b1);
        send(1'b1, 91, 1'b1);
        send(1'b0, 92, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst saidaA_valida", W'(saidaA_valida), 0);
        check("arst saidaB_valida", W'(saidaB_valida), 0);
        check("arst saidaA", saidaA, 0);
        check("arst saidaB", saidaB, 0);
        check("arst ocupacaoA", W'(ocupacaoA), 0);
        check("arst ocupacaoB", W'(ocupacaoB), 0);
        check("arst entrada_pronta", W'(entrada_pronta), 1);
        qa.delete();
        qb.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        idle(3);
        send(1'b1, 95, 1'b1);
        idle(1);
        saidaB_pronta = 1'b1;
        idle(3);
        saidaB_pronta = 1'b0;

        check("end qa empty", W'(qa.size()), 0);
        check("end qb empty", W'(qb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
